// File: rtl/counter_chk_pkg.sv
// counter_chk_pkg
//   Shared types and constants for the counter sequence checker.
//   - chk_state_t : checker FSM state encoding (IDLE, TRACK, FAULT)
//   - CNT_WIDTH / CNT_MAX : default monitored width and its maximum value
//   - cnt_max_f  : maximum count for an arbitrary monitored width
package counter_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } chk_state_t;

  localparam int CNT_WIDTH = 5;
  localparam int CNT_MAX   = 2**CNT_WIDTH - 1;

  // Largest value representable in a w-bit counter.
  function automatic int cnt_max_f(input int w);
    return (2**w) - 1;
  endfunction

endpackage

// File: rtl/counter_seq_checker_sat_counter.sv
// sat_counter
//   Saturating up-counter: increments on inc, sticks at all-ones, and
//   clears synchronously on clr or reset (clr wins over inc).
//   Ports:
//     clk   in  : clock, rising edge
//     reset in  : synchronous active-high reset
//     inc   in  : increment request
//     clr   in  : synchronous clear
//     q     out : registered count, W bits
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_seq_checker.sv
// counter_seq_checker
//   Monitors a free-running up-counter and checks that every live sample
//   equals the previous live sample plus one, modulo 2^WIDTH.
//   Ports:
//     clk        in  : clock, rising edge
//     reset      in  : synchronous active-high reset
//     cnt_in     in  : counter value under check (WIDTH)
//     cnt_valid  in  : 1 = cnt_in is a live sample
//     clr        in  : synchronous clear of statistics and fault
//     locked     out : tracking with no outstanding error
//     wrap_pulse out : one-cycle pulse on a max -> 0 step
//     wrap_count out : saturating wrap count (WRAP_CNT_W)
//     step_err   out : one-cycle pulse on a bad step
//     err_count  out : saturating bad-step count (ERR_CNT_W)
//     fault      out : sticky, set after ERR_LIMIT consecutive bad steps
//     dbg_state  out : current FSM state
//
//   Handshake: cnt_valid is a qualifier only (no ready). A sample is
//   consumed on every rising edge where cnt_valid=1; a cnt_valid=0 cycle
//   breaks the sequence and the next live sample is captured, not checked.
module counter_seq_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int WRAP_CNT_W = 8,
  parameter int ERR_CNT_W  = 8,
  parameter int ERR_LIMIT  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic                  cnt_valid,
  input  logic                  clr,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  step_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  fault,
  output chk_state_t            dbg_state
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(cnt_max_f(WIDTH));
  localparam logic [3:0]       ERR_LIM = 4'(ERR_LIMIT);

  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       consec_q, consec_d;
  logic             locked_q, locked_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] prev_inc;
  logic [3:0]       consec_inc;

  assign prev_inc   = prev_q + WIDTH'(1);
  assign consec_inc = consec_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    consec_d = consec_q;
    locked_d = locked_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    fault_d  = fault_q;

    if (clr) begin
      // Sample discarded, no pulses; prev is irrelevant since IDLE recaptures.
      state_d  = IDLE;
      consec_d = '0;
      locked_d = 1'b0;
      fault_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          locked_d = 1'b0;
          if (cnt_valid) begin
            prev_d  = cnt_in;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (!cnt_valid) begin
            state_d  = IDLE;
            locked_d = 1'b0;
          end else begin
            prev_d = cnt_in;
            if (cnt_in == prev_inc) begin
              consec_d = '0;
              locked_d = 1'b1;
              wrap_d   = (prev_q == MAX_VAL);
            end else begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              consec_d = consec_inc;
              if (consec_inc >= ERR_LIM) begin
                state_d = FAULT;
                fault_d = 1'b1;
              end
            end
          end
        end
        FAULT: begin
          locked_d = 1'b0;
          fault_d  = 1'b1;
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      consec_q <= '0;
      locked_q <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      consec_q <= consec_d;
      locked_q <= locked_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      fault_q  <= fault_d;
    end
  end

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_d),
    .clr   (clr),
    .q     (wrap_count)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_d),
    .clr   (clr),
    .q     (err_count)
  );

  assign locked     = locked_q;
  assign wrap_pulse = wrap_q;
  assign step_err   = err_q;
  assign fault      = fault_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/counter_seq_checker.md
Name: counter_seq_checker

Overview:
Downstream consumer of the 5-bit up-counter output. It samples the count every clock and checks that each enabled sample equals the previous sample plus 1, modulo 2^WIDTH. It reports wrap events (max -> 0), step errors, a lock indication and a sticky fault. It sits between the counter and status/compare logic in the post-route test harness and in the on-chip self-check path.

Parameters:
WIDTH, 5, width of the monitored count.
WRAP_CNT_W, 8, width of the wrap-event counter.
ERR_CNT_W, 8, width of the step-error counter.
ERR_LIMIT, 3, consecutive step errors that force FAULT (legal range 1..15).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous reset, active-high.
cnt_in  input  WIDTH  counter value under check.
cnt_valid  input  1  1 = counter enabled and cnt_in is a live sample; 0 = counter held or cleared.
clr  input  1  synchronous clear of statistics and fault.
locked  output  1  tracking with no outstanding error.
wrap_pulse  output  1  one-cycle pulse on a detected max -> 0 step.
wrap_count  output  WRAP_CNT_W  saturating count of wraps.
step_err  output  1  one-cycle pulse on a detected bad step.
err_count  output  ERR_CNT_W  saturating count of bad steps.
fault  output  1  sticky; set on ERR_LIMIT consecutive errors.

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named clk and reset.
- Reset values: every output 0. FSM = IDLE; prev = 0; consec_err = 0.
- All outputs are registered. A sample taken at edge N is reflected on the outputs after edge N.
- FSM states and transitions:
  - IDLE: cnt_valid=1 -> capture prev=cnt_in, go to TRACK. No check is made on the first sample.
  - TRACK, cnt_valid=0 -> go to IDLE. locked=0. The sample is ignored and counters are held.
  - TRACK, cnt_valid=1, cnt_in == prev+1 (mod 2^WIDTH) -> good step. consec_err=0, locked=1.
    - If prev == 2^WIDTH-1 and cnt_in == 0: wrap_pulse=1 and wrap_count increments.
  - TRACK, cnt_valid=1, bad step -> step_err=1, err_count increments, consec_err increments, locked=0.
    - prev is re-referenced to cnt_in.
    - If consec_err reaches ERR_LIMIT: go to FAULT and set fault=1.
  - FAULT: absorbing. locked=0; wrap and err counters are held. Exit only via clr or reset, both of which go to IDLE.
- prev updates on every cnt_valid=1 cycle in TRACK.
- A repeated value (cnt_in == prev) counts as a bad step.
- wrap_count and err_count saturate at all-ones; they never roll over.
- wrap_pulse and step_err are mutually exclusive and are single-cycle pulses.
- clr (synchronous, any state):
  - clears wrap_count, err_count, fault, consec_err and locked;
  - FSM goes to IDLE;
  - that cycle's sample is discarded and no pulses are issued.
- clr together with reset behaves identically to reset.
- Reset mid-operation discards all state. The checker resyncs on the next valid sample, taking one cycle to capture before checking.
- cnt_valid toggling causes a resync each time. The sample after a gap is never checked against the pre-gap value.

Decomposition:
- Package counter_chk_pkg holds:
  - typedef enum logic [1:0] {IDLE, TRACK, FAULT} chk_state_t;
  - localparam CNT_MAX = 2**WIDTH-1 (function of WIDTH).
- One sub-module, sat_counter (parameter W; ports inc, clr, q): a saturating incrementer instantiated twice, for wrap_count and err_count.

Test Plan:
- Reset, then cnt_valid=1 with cnt_in 0,1,…,31,0,1.
  - locked=1 from the second sample onward.
  - Exactly one wrap_pulse, on 31 -> 0; wrap_count=1; err_count=0; step_err never asserted.
- Sequence 4,5,9,10.
  - One step_err, at sample 9; err_count=1; locked falls at 9 and returns at 10.
  - fault=0.
- Sequence 7,7,7,7 (ERR_LIMIT=3).
  - step_err on samples 2, 3 and 4; fault=1 after the 4th sample; locked=0.
  - Further good steps leave fault=1 and err_count=3.
- cnt_valid low for 5 cycles mid-count (12 -> gap -> 0).
  - No step_err; locked=0 during the gap and for the first post-gap sample; locked=1 after the second post-gap sample.
- Force 300 wraps with WRAP_CNT_W=8.
  - wrap_count saturates at 255.
  - clr asserted together with a wrap sample -> wrap_count=0 and no wrap_pulse.
- Assert reset during TRACK with cnt_in=17.
  - All outputs 0 on the next cycle.
  - The next sample (18) is captured only; the one after (19) is checked good.
